axil_adder_responder: RTL and testbench

AXI4-Lite slave that serves as the responder counterpart of the VIP-driven master in our test environments. It exposes an operand register plus read-only "add one" and "add two" results (VALUE_1 / VALUE_2 semantics), together with a write counter and an ID word. It sits behind the AXI VIP master port in the example testbench and gives the patched VIP a real slave to handshake with, including back-pressure and error responses.

---
 rtl/axil_adder_responder.sv | 191 +++++++++++++++++++
 tb/tb_axil_adder_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_adder_responder.sv
// AXI4-Lite slave: operand register with +1/+2 read-only results,
// a write counter and a constant ID word.
module axil_adder_responder #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] ID_VALUE   = 32'h0AD0_0001
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_DATA } rstate_e;

    wstate_e               w_state_q;
    rstate_e               r_state_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic                  arready_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [31:0]           rdata_q;
    logic                  aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           operand_q, operand_d;
    logic [31:0]           wr_count_q;

    logic                  aw_hs, w_hs, aw_have, w_have, commit, wr_ok;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  ar_hs, ar_mapped;
    logic [31:0]           ar_data;

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot,
                             s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

    // AW and W may arrive in either order; a held beat stands in for the live one.
    assign aw_hs   = s_axil_awvalid && awready_q;
    assign w_hs    = s_axil_wvalid && wready_q;
    assign aw_have = aw_held_q || aw_hs;
    assign w_have  = w_held_q || w_hs;
    assign commit  = (w_state_q == W_IDLE) && aw_have && w_have;
    assign wr_addr = aw_held_q ? awaddr_q : s_axil_awaddr;
    assign wr_data = w_held_q ? wdata_q : s_axil_wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_axil_wstrb;
    assign wr_ok   = (wr_addr[ADDR_WIDTH-1:5] == '0) && (wr_addr[4:2] == 3'd1);

    always_comb begin
        operand_d = operand_q;
        for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) operand_d[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            operand_q  <= '0;
            wr_count_q <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (commit) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_ok ? OKAY : SLVERR;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        if (wr_ok) begin
                            operand_q  <= operand_d;
                            wr_count_q <= wr_count_q + 32'd1;
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s_axil_awaddr;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s_axil_wdata;
                            wstrb_q  <= s_axil_wstrb;
                        end
                        awready_q <= !aw_have;
                        wready_q  <= !w_have;
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign ar_hs = s_axil_arvalid && arready_q;

    always_comb begin
        ar_data   = '0;
        ar_mapped = (s_axil_araddr[ADDR_WIDTH-1:5] == '0);
        case (s_axil_araddr[4:2])
            3'd0:    ar_data = ID_VALUE;
            3'd1:    ar_data = operand_q;
            3'd2:    ar_data = operand_q + 32'd1;
            3'd3:    ar_data = operand_q + 32'd2;
            3'd4:    ar_data = wr_count_q;
            default: ar_mapped = 1'b0;
        endcase
        if (!ar_mapped) ar_data = '0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= ar_data;
                        rresp_q   <= ar_mapped ? OKAY : SLVERR;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        r_state_q <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_adder_responder.sv
// Directed bench for axil_adder_responder: handshakes, arithmetic,
// strobes, error responses and asynchronous reset.
module tb_axil_adder_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axil_adder_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready)
    );

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit awd = 0, wd = 0, got = 0;
        resp = 2'bxx;
        @(posedge aclk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 20 && !(awd && wd); i++) begin
            @(negedge aclk);
            if (awvalid && awready) awd = 1;
            if (wvalid && wready) wd = 1;
            @(posedge aclk); #1;
            if (awd) awvalid = 0;
            if (wd) wvalid = 0;
        end
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge aclk);
            if (bvalid) begin
                got = 1; resp = bresp; bready = 1;
                @(posedge aclk); #1; bready = 0;
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL write_timeout addr=%h", a);
        end
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output int lat);
        bit ard = 0, got = 0;
        d = 'x; resp = 2'bxx; lat = -1;
        @(posedge aclk); #1;
        araddr = a; arvalid = 1;
        for (int i = 0; i < 20 && !ard; i++) begin
            @(negedge aclk);
            if (arready) ard = 1;
            @(posedge aclk); #1;
        end
        arvalid = 0;
        for (int i = 1; i < 20 && ard && !got; i++) begin
            @(negedge aclk);
            if (rvalid) begin
                got = 1; lat = i; d = rdata; resp = rresp; rready = 1;
                @(posedge aclk); #1; rready = 0;
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL read_timeout addr=%h", a);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int lat;
        aresetn = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hs got %b exp 00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if ({rdata, rresp, bresp} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b exp 0",
                     rdata, rresp, bresp);
        end
        @(posedge aclk); #1; aresetn = 1;
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL ready_early got %b exp 000", {awready, wready, arready});
        end
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_rise got %b exp 111", {awready, wready, arready});
        end
        axi_read(8'h00, d, r, lat);
        checks++;
        if (d !== 32'h0AD0_0001 || r !== 2'b00 || lat !== 1) begin
            errors++;
            $display("FAIL read_id got %h/%b/lat%0d exp 0ad00001/00/lat1", d, r, lat);
        end
    endtask

    task automatic test_add();
        logic [31:0] d; logic [1:0] r; int lat;
        logic [7:0]  addrs [3] = '{8'h08, 8'h0C, 8'h10};
        logic [31:0] exps  [3] = '{32'h11, 32'h12, 32'h1};
        axi_write(8'h04, 32'h10, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin
            errors++; $display("FAIL add_bresp got %b exp 00", r);
        end
        for (int i = 0; i < 3; i++) begin
            axi_read(addrs[i], d, r, lat);
            checks++;
            if (d !== exps[i] || r !== 2'b00) begin
                errors++;
                $display("FAIL add_read@%h got %h/%b exp %h/00", addrs[i], d, r, exps[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic [1:0] r; int lat;
        axi_write(8'h04, 32'hFFFF_FFFF, 4'hF, r);
        axi_read(8'h08, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL wrap_one got %h/%b exp 00000000/00", d, r);
        end
        axi_read(8'h0C, d, r, lat);
        checks++;
        if (d !== 32'h1 || r !== 2'b00) begin
            errors++; $display("FAIL wrap_two got %h/%b exp 00000001/00", d, r);
        end
    endtask

    task automatic test_split();
        logic [31:0] d; logic [1:0] r; int lat;
        axi_write(8'h04, 32'h1111_1111, 4'hF, r);
        @(posedge aclk); #1;
        wdata = 32'hAABB_CCDD; wstrb = 4'h2; wvalid = 1;
        @(negedge aclk);
        checks++;
        if (wready !== 1'b1) begin
            errors++; $display("FAIL split_wready got %b exp 1", wready);
        end
        @(posedge aclk); #1; wvalid = 0;
        repeat (2) begin
            @(negedge aclk);
            checks++;
            if ({bvalid, wready, awready} !== 3'b001) begin
                errors++;
                $display("FAIL split_wait got bvalid/wready/awready=%b exp 001",
                         {bvalid, wready, awready});
            end
        end
        awaddr = 8'h04; awvalid = 1;
        @(posedge aclk); #1; awvalid = 0;
        repeat (3) begin
            @(negedge aclk);
            checks++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
                errors++;
                $display("FAIL split_bhold got %b exp 10000",
                         {bvalid, bresp, awready, wready});
            end
        end
        bready = 1;
        @(posedge aclk); #1; bready = 0;
        @(negedge aclk);
        checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            errors++;
            $display("FAIL split_after got %b exp 011", {bvalid, awready, wready});
        end
        axi_read(8'h04, d, r, lat);
        checks++;
        if (d !== 32'h1111_CC11) begin
            errors++; $display("FAIL split_strb got %h exp 1111cc11", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r; int lat;
        logic [7:0] bad [3] = '{8'h08, 8'h20, 8'h14};
        for (int i = 0; i < 3; i++) begin
            axi_write(bad[i], 32'hDEAD_BEEF, 4'hF, r);
            checks++;
            if (r !== 2'b10) begin
                errors++; $display("FAIL err_bresp@%h got %b exp 10", bad[i], r);
            end
        end
        axi_read(8'h04, d, r, lat);
        checks++;
        if (d !== 32'h1111_CC11) begin
            errors++; $display("FAIL err_operand got %h exp 1111cc11", d);
        end
        axi_read(8'h10, d, r, lat);
        checks++;
        if (d !== 32'd4) begin
            errors++; $display("FAIL err_count got %h exp 00000004", d);
        end
        axi_read(8'h20, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("FAIL err_read got %h/%b exp 00000000/10", d, r);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d; logic [1:0] r; int lat;
        @(posedge aclk); #1;
        awaddr = 8'h04; wdata = 32'h5; wstrb = 4'hF; araddr = 8'h08;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge aclk);
        checks++;
        if ({bvalid, rvalid} !== 2'b11 || rdata !== 32'h1111_CC12) begin
            errors++;
            $display("FAIL simul got b/r=%b rdata=%h exp 11/1111cc12",
                     {bvalid, rvalid}, rdata);
        end
        bready = 1; rready = 1;
        @(posedge aclk); #1; bready = 0; rready = 0;
        axi_read(8'h08, d, r, lat);
        checks++;
        if (d !== 32'h6) begin
            errors++; $display("FAIL simul_after got %h exp 00000006", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int lat;
        @(posedge aclk); #1;
        araddr = 8'h04; arvalid = 1;
        @(posedge aclk); #1; arvalid = 0;
        @(negedge aclk);
        checks++;
        if (rvalid !== 1'b1) begin
            errors++; $display("FAIL mid_rvalid got %b exp 1", rvalid);
        end
        aresetn = 0;
        #1;
        checks++;
        if ({rvalid, arready, rdata} !== 34'h0) begin
            errors++;
            $display("FAIL mid_async got rvalid=%b arready=%b rdata=%h exp 0",
                     rvalid, arready, rdata);
        end
        @(posedge aclk); #1; aresetn = 1;
        @(negedge aclk);
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready, rvalid} !== 4'b1110) begin
            errors++;
            $display("FAIL mid_ready got %b exp 1110",
                     {awready, wready, arready, rvalid});
        end
        axi_read(8'h04, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL mid_operand got %h/%b exp 0/00", d, r);
        end
        axi_read(8'h10, d, r, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL mid_count got %h exp 0", d);
        end
    endtask

    initial begin
        aresetn = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; rready = 0;
        test_reset();
        test_add();
        test_wrap();
        test_split();
        test_errors();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
